cam_bram_mm: RTL and testbench
==============================

# cam_bram_mm

Block-RAM content addressable memory with a valid/ready write port, true replace-on-overwrite, a pipelined compare port and multi-match reporting. Entry data is split into SLICE_WIDTH-bit slices; each slice addresses one dual-port RAM whose RAM_DEPTH-bit word holds one match bit per entry. A shadow RAM keeps each entry's stored data, so overwrite and delete clear the old bits without the caller resupplying data. It sits between a lookup client, such as an address-translation or tag-match stage, and the controller that owns the table.

## Interface
- DATA_WIDTH, 16, width of stored and compared data.
- ADDR_WIDTH, 5, log2 of the entry count; RAM_DEPTH = 2**ADDR_WIDTH.
- SLICE_WIDTH, 4, bits per slice; SLICE_COUNT = ceil(DATA_WIDTH/SLICE_WIDTH); the last slice is narrower if DATA_WIDTH does not divide evenly.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- clear  in  1  synchronous re-initialise; empties the table.
- wr_valid  in  1  write request.
- wr_ready  out  1  ready for a write request.
- wr_op  in  1  0 = write, 1 = delete.
- wr_addr  in  ADDR_WIDTH  target entry.
- wr_data  in  DATA_WIDTH  data to store; ignored for delete.
- cmp_valid  in  1  compare request; accepted every cycle.
- cmp_data  in  DATA_WIDTH  compare key.
- match_valid  out  1  compare result strobe.
- match  out  1  at least one entry hit.
- match_multi  out  1  two or more entries hit.
- match_addr  out  ADDR_WIDTH  lowest-index hitting entry.
- match_vec  out  RAM_DEPTH  all hitting entries.
- entry_valid  out  RAM_DEPTH  occupancy bitmap.
- count  out  ADDR_WIDTH+1  number of valid entries.
- full  out  1  count == RAM_DEPTH.

## Operation
- States:
  - INIT: sweep rows 2**SLICE_WIDTH-1 down to 0, writing all-zero words to every slice RAM. Takes 2**SLICE_WIDTH cycles, then goes to IDLE.
  - IDLE: wr_ready = 1 only in this state.
  - RD_OLD: read the shadow RAM and the slice rows for the old data.
  - CLR_OLD: write back the rows with bit[addr] cleared.
  - RD_NEW: read the slice rows for the new data.
  - SET_NEW: write back the rows with bit[addr] set, and write the shadow RAM.
- A request is accepted when wr_valid and wr_ready are both high. Acceptance latches wr_op, wr_addr and wr_data.
- Write to an invalid entry: IDLE, RD_NEW, SET_NEW, IDLE.
- Write to a valid entry: IDLE, RD_OLD, CLR_OLD, RD_NEW, SET_NEW, IDLE.
- Delete of a valid entry: IDLE, RD_OLD, CLR_OLD, IDLE.
- Delete of an invalid entry: no-op; stays in IDLE and wr_ready stays high.
- entry_valid[addr] is cleared on acceptance of a delete or an overwrite, and set on the SET_NEW commit. count tracks entry_valid.
- A write while full is legal; it is always an overwrite and count is unchanged.
- Compare: raw hit vector = AND over slices of each slice RAM's row[cmp_data slice], masked by entry_valid as sampled at issue. match_addr uses LSB priority; match_multi means popcount ≥ 2.
- Compares run concurrently with writes on the other RAM port; they are never stalled.
- clear: from any state, go to INIT next cycle. An in-flight operation is aborted. entry_valid becomes 0 and count becomes 0 the next cycle.

## Timing
- Reset values: wr_ready = 0, match_valid = 0, match = 0, match_multi = 0, match_addr = 0, match_vec = 0, entry_valid = 0, count = 0, full = 0.
- After reset or clear, the state is INIT. wr_ready rises after 2**SLICE_WIDTH cycles (16 at defaults).
- Write latency: SET_NEW commits 2 cycles after acceptance for a fresh entry, 4 cycles after acceptance for an overwrite. wr_ready returns the cycle after the commit.
- Compare latency: fixed 2 cycles, from cmp_valid at cycle t to match_valid at t+2. Stage 1 is the RAM read plus the entry_valid snapshot; stage 2 is the registered AND, encode and popcount.
- Coherence:
  - A compare issued the cycle after a SET_NEW commit sees the new entry.
  - A compare issued in the acceptance cycle of a delete or overwrite, or later, no longer hits that entry's old data.
- Compares issued during INIT return match_valid with match = 0.
- rst while mid-operation: immediate return to reset values. The RAMs are not cleared by rst; INIT clears them.

## Structure
- Shared package cam_pkg holds:
  - state enum: INIT, IDLE, RD_OLD, CLR_OLD, RD_NEW, SET_NEW;
  - wr_op encodings: OP_WRITE = 0, OP_DELETE = 1;
  - SLICE_COUNT computation function.
- The per-slice RAM is the existing ram_dp, one instance per slice in a generate loop. The shadow RAM is one further ram_dp, DATA_WIDTH wide by RAM_DEPTH deep.
- The existing priority_encoder is reused with LSB priority.
- No other sub-module.

## Test plan
All runs use the defaults 16/5/4.
- Reset, then hold the bus idle: wr_ready is 0 for 16 cycles, then 1. A compare of 0x0000 gives match_valid with match = 0.
- Write addr 3 = 0xBEEF, then compare 0xBEEF: match = 1, match_addr = 3, match_vec = 0x00000008, count = 1.
- Write addr 7 = 0xBEEF as well, then compare 0xBEEF: match_addr = 3, match_multi = 1, match_vec = 0x00000088.
- Overwrite addr 3 = 0x1234: wr_ready is low for 4 cycles. A compare of 0xBEEF then gives match_addr = 7 only; a compare of 0x1234 gives match_addr = 3; count stays at 2.
- Delete addr 7 and delete addr 9 (invalid):
  - a compare of 0xBEEF issued in the acceptance cycle of the addr 7 delete gives match = 0;
  - the addr 9 delete leaves wr_ready high;
  - count = 1.
- Fill all 32 entries so full = 1, then assert clear mid-overwrite: the operation is aborted, count = 0, INIT runs for 16 cycles, and every compare returns match = 0.

Source files
------------

// File: rtl/cam_bram_mm_pkg.sv
// Shared types and helpers for the block-RAM CAM.
package cam_pkg;

  typedef enum logic [2:0] {
    INIT    = 3'd0,
    IDLE    = 3'd1,
    RD_OLD  = 3'd2,
    CLR_OLD = 3'd3,
    RD_NEW  = 3'd4,
    SET_NEW = 3'd5
  } state_t;

  localparam logic OP_WRITE  = 1'b0;
  localparam logic OP_DELETE = 1'b1;

  // Number of slices needed to cover the data word; the last may be narrower.
  function automatic int slice_count(input int data_width, input int slice_width);
    return (data_width + slice_width - 1) / slice_width;
  endfunction

endpackage

// File: rtl/priority_encoder.sv
// Priority encoder: returns the index of the highest-priority set bit.
module priority_encoder #(
  parameter int WIDTH     = 32,
  parameter int IDX_W     = 5,
  parameter int LSB_FIRST = 1
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_found
);

  logic [IDX_W-1:0] w_idx;
  logic             w_found;

  // Scan from lowest to highest priority so the last hit seen wins.
  always_comb begin
    w_idx   = {IDX_W{1'b0}};
    w_found = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      int j;
      j       = (LSB_FIRST != 0) ? (WIDTH - 1 - i) : i;
      w_idx   = i_vec[j] ? IDX_W'(j) : w_idx;
      w_found = w_found | i_vec[j];
    end
  end

  assign o_idx   = w_idx;
  assign o_found = w_found;

endmodule

// File: rtl/ram_dp.sv
// Dual-port RAM: port A read/write (read-first), port B read-only, both registered.
module ram_dp #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              i_a_we,
  input  logic [ADDR_W-1:0] i_a_addr,
  input  logic [WIDTH-1:0]  i_a_din,
  output logic [WIDTH-1:0]  o_a_dout,
  input  logic [ADDR_W-1:0] i_b_addr,
  output logic [WIDTH-1:0]  o_b_dout
);

  logic [WIDTH-1:0] r_mem [0:(2**ADDR_W)-1];
  logic [WIDTH-1:0] r_a_dout;
  logic [WIDTH-1:0] r_b_dout;

  // Storage write on port A and registered reads on both ports.
  always_ff @(posedge clk) begin
    if (i_a_we) begin
      r_mem[i_a_addr] <= i_a_din;
    end
    r_a_dout <= r_mem[i_a_addr];
    r_b_dout <= r_mem[i_b_addr];
  end

  assign o_a_dout = r_a_dout;
  assign o_b_dout = r_b_dout;

endmodule

// File: rtl/cam_bram_mm.sv
// Block-RAM CAM: sliced match-bit RAMs, shadow data RAM, 2-cycle compare pipe.
module cam_bram_mm
  import cam_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 5,
  parameter int SLICE_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic                     wr_op,
  input  logic [ADDR_WIDTH-1:0]    wr_addr,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     cmp_valid,
  input  logic [DATA_WIDTH-1:0]    cmp_data,
  output logic                     match_valid,
  output logic                     match,
  output logic                     match_multi,
  output logic [ADDR_WIDTH-1:0]    match_addr,
  output logic [2**ADDR_WIDTH-1:0] match_vec,
  output logic [2**ADDR_WIDTH-1:0] entry_valid,
  output logic [ADDR_WIDTH:0]      count,
  output logic                     full
);

  localparam int RD  = 2**ADDR_WIDTH;
  localparam int SC  = slice_count(DATA_WIDTH, SLICE_WIDTH);
  localparam int PAD = SC * SLICE_WIDTH;

  state_t                  r_state, w_next_state;
  logic [SLICE_WIDTH-1:0]  r_init_row;
  logic                    r_op;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [RD-1:0]           r_entry_valid, w_ev_next;
  logic [ADDR_WIDTH:0]     r_count, w_count_next;
  logic                    r_full;
  logic                    w_ready, w_accept, w_old_valid, w_kill, w_set;
  logic                    w_slice_we, w_shadow_we;
  logic [RD-1:0]           w_onehot_r, w_onehot_wr;
  logic [PAD-1:0]          w_old_pad, w_new_pad, w_cmp_pad;
  logic [DATA_WIDTH-1:0]   w_shadow_dout, w_shadow_b_unused;
  logic [ADDR_WIDTH-1:0]   w_shadow_addr;
  logic [RD-1:0]           w_row_a [SC];
  logic [RD-1:0]           w_row_b [SC];
  logic                    r_s1_valid;
  logic [RD-1:0]           r_s1_mask;
  logic [RD-1:0]           w_hit;
  logic [ADDR_WIDTH-1:0]   w_pe_idx;
  logic                    w_pe_found;
  logic                    r_match_valid, r_match, r_match_multi;
  logic [ADDR_WIDTH-1:0]   r_match_addr;
  logic [RD-1:0]           r_match_vec;

  assign w_onehot_r  = {{(RD-1){1'b0}}, 1'b1} << r_addr;
  assign w_onehot_wr = {{(RD-1){1'b0}}, 1'b1} << wr_addr;
  assign w_old_pad   = PAD'(w_shadow_dout);
  assign w_new_pad   = PAD'(r_data);
  assign w_cmp_pad   = PAD'(cmp_data);
  assign w_old_valid = r_entry_valid[wr_addr];
  assign w_accept    = wr_valid & w_ready & ~clear;
  assign w_kill      = w_accept & w_old_valid;

  // State register and INIT sweep row counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= INIT;
      r_init_row <= {SLICE_WIDTH{1'b1}};
    end else begin
      r_state <= w_next_state;
      if (clear) begin
        r_init_row <= {SLICE_WIDTH{1'b1}};
      end else if (r_state == INIT) begin
        r_init_row <= r_init_row - SLICE_WIDTH'(1);
      end else begin
        r_init_row <= r_init_row;
      end
    end
  end

  // Next-state logic; clear aborts anything in flight.
  always_comb begin
    w_next_state = r_state;
    if (clear) begin
      w_next_state = INIT;
    end else begin
      case (r_state)
        INIT:    w_next_state = (r_init_row == {SLICE_WIDTH{1'b0}}) ? IDLE : INIT;
        IDLE: begin
          if (w_accept && w_old_valid) begin
            w_next_state = RD_OLD;
          end else if (w_accept && (wr_op == OP_WRITE)) begin
            w_next_state = RD_NEW;
          end else begin
            w_next_state = IDLE;
          end
        end
        RD_OLD:  w_next_state = CLR_OLD;
        CLR_OLD: w_next_state = (r_op == OP_DELETE) ? IDLE : RD_NEW;
        RD_NEW:  w_next_state = SET_NEW;
        SET_NEW: w_next_state = IDLE;
        default: w_next_state = INIT;
      endcase
    end
  end

  // State-decoded controls for the RAM ports and the handshake.
  always_comb begin
    w_ready       = 1'b0;
    w_slice_we    = 1'b0;
    w_shadow_we   = 1'b0;
    w_set         = 1'b0;
    w_shadow_addr = r_addr;
    case (r_state)
      INIT:    w_slice_we = 1'b1;
      IDLE: begin
        w_ready       = 1'b1;
        w_shadow_addr = wr_addr;
      end
      CLR_OLD: w_slice_we = 1'b1;
      SET_NEW: begin
        w_slice_we  = 1'b1;
        w_shadow_we = 1'b1;
        w_set       = 1'b1;
      end
      default: w_slice_we = 1'b0;
    endcase
  end

  // Occupancy update: cleared on accepted kill, set on commit.
  always_comb begin
    w_ev_next    = r_entry_valid;
    w_count_next = r_count;
    if (clear) begin
      w_ev_next    = {RD{1'b0}};
      w_count_next = {(ADDR_WIDTH+1){1'b0}};
    end else begin
      w_ev_next    = (r_entry_valid & ~(w_kill ? w_onehot_wr : {RD{1'b0}}))
                   | (w_set ? w_onehot_r : {RD{1'b0}});
      w_count_next = r_count + (ADDR_WIDTH+1)'(w_set) - (ADDR_WIDTH+1)'(w_kill);
    end
  end

  // Request latch and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op          <= OP_WRITE;
      r_addr        <= {ADDR_WIDTH{1'b0}};
      r_data        <= {DATA_WIDTH{1'b0}};
      r_entry_valid <= {RD{1'b0}};
      r_count       <= {(ADDR_WIDTH+1){1'b0}};
      r_full        <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op   <= wr_op;
        r_addr <= wr_addr;
        r_data <= wr_data;
      end
      r_entry_valid <= w_ev_next;
      r_count       <= w_count_next;
      r_full        <= (w_count_next == (ADDR_WIDTH+1)'(RD));
    end
  end

  for (genvar g = 0; g < SC; g++) begin : g_slice
    logic [SLICE_WIDTH-1:0] w_a_addr;
    logic [RD-1:0]          w_a_din;

    // Row select and read-modify-write data for this slice's RAM.
    always_comb begin
      w_a_addr = w_new_pad[g*SLICE_WIDTH +: SLICE_WIDTH];
      w_a_din  = w_row_a[g] | w_onehot_r;
      case (r_state)
        INIT: begin
          w_a_addr = r_init_row;
          w_a_din  = {RD{1'b0}};
        end
        RD_OLD, CLR_OLD: begin
          w_a_addr = w_old_pad[g*SLICE_WIDTH +: SLICE_WIDTH];
          w_a_din  = w_row_a[g] & ~w_onehot_r;
        end
        default: begin
          w_a_addr = w_new_pad[g*SLICE_WIDTH +: SLICE_WIDTH];
          w_a_din  = w_row_a[g] | w_onehot_r;
        end
      endcase
    end

    ram_dp #(.WIDTH(RD), .ADDR_W(SLICE_WIDTH)) u_slice_ram (
      .clk      (clk),
      .i_a_we   (w_slice_we),
      .i_a_addr (w_a_addr),
      .i_a_din  (w_a_din),
      .o_a_dout (w_row_a[g]),
      .i_b_addr (w_cmp_pad[g*SLICE_WIDTH +: SLICE_WIDTH]),
      .o_b_dout (w_row_b[g])
    );
  end

  ram_dp #(.WIDTH(DATA_WIDTH), .ADDR_W(ADDR_WIDTH)) u_shadow_ram (
    .clk      (clk),
    .i_a_we   (w_shadow_we),
    .i_a_addr (w_shadow_addr),
    .i_a_din  (r_data),
    .o_a_dout (w_shadow_dout),
    .i_b_addr (r_addr),
    .o_b_dout (w_shadow_b_unused)
  );

  // AND of all slice rows, masked by occupancy captured at issue.
  always_comb begin
    w_hit = r_s1_mask;
    for (int s = 0; s < SC; s++) begin
      w_hit = w_hit & w_row_b[s];
    end
  end

  priority_encoder #(.WIDTH(RD), .IDX_W(ADDR_WIDTH), .LSB_FIRST(1)) u_pe (
    .i_vec   (w_hit),
    .o_idx   (w_pe_idx),
    .o_found (w_pe_found)
  );

  // Compare pipeline: stage 1 snapshot, stage 2 registered result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid    <= 1'b0;
      r_s1_mask     <= {RD{1'b0}};
      r_match_valid <= 1'b0;
      r_match       <= 1'b0;
      r_match_multi <= 1'b0;
      r_match_addr  <= {ADDR_WIDTH{1'b0}};
      r_match_vec   <= {RD{1'b0}};
    end else begin
      r_s1_valid    <= cmp_valid;
      r_s1_mask     <= w_ev_next;
      r_match_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_match       <= w_pe_found;
        r_match_multi <= |(w_hit & (w_hit - RD'(1)));
        r_match_addr  <= w_pe_idx;
        r_match_vec   <= w_hit;
      end
    end
  end

  assign wr_ready    = w_ready;
  assign match_valid = r_match_valid;
  assign match       = r_match;
  assign match_multi = r_match_multi;
  assign match_addr  = r_match_addr;
  assign match_vec   = r_match_vec;
  assign entry_valid = r_entry_valid;
  assign count       = r_count;
  assign full        = r_full;

endmodule

// File: tb/tb_cam_bram_mm.sv
// Directed, table-driven bench for cam_bram_mm at default parameters.
module tb_cam_bram_mm;

  logic        clk = 1'b0;
  logic        rst, clear, wr_valid, wr_op, cmp_valid;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data, cmp_data;
  logic        wr_ready, match_valid, match, match_multi, full;
  logic [4:0]  match_addr;
  logic [31:0] match_vec, entry_valid;
  logic [5:0]  count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        is_cmp;
    logic        op;
    logic [4:0]  addr;
    logic [15:0] data;
    int          busy;
    logic        em;
    logic        emu;
    logic [4:0]  ea;
    logic [31:0] ev;
    int          cnt;
  } vec_t;

  vec_t tv[9];

  cam_bram_mm dut (
    .clk(clk), .rst(rst), .clear(clear),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_op(wr_op),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .cmp_valid(cmp_valid), .cmp_data(cmp_data),
    .match_valid(match_valid), .match(match), .match_multi(match_multi),
    .match_addr(match_addr), .match_vec(match_vec),
    .entry_valid(entry_valid), .count(count), .full(full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_wr(input logic op, input logic [4:0] a, input logic [15:0] d,
                       input int exp_busy, input string nm);
    int n;
    int busy;
    n = 0;
    while (!wr_ready && n < 40) begin
      step();
      n++;
    end
    chk({nm, "_ready_wait"}, 64'(wr_ready), 64'd1);
    wr_valid = 1'b1;
    wr_op    = op;
    wr_addr  = a;
    wr_data  = d;
    step();
    wr_valid = 1'b0;
    busy = 0;
    while (!wr_ready && busy < 40) begin
      step();
      busy++;
    end
    chk({nm, "_busy"}, 64'(busy), 64'(exp_busy));
  endtask

  task automatic do_cmp(input logic [15:0] key, input logic em, input logic emu,
                        input logic [4:0] ea, input logic [31:0] ev, input string nm);
    cmp_valid = 1'b1;
    cmp_data  = key;
    step();
    cmp_valid = 1'b0;
    step();
    chk({nm, "_mvalid"}, 64'(match_valid), 64'd1);
    chk({nm, "_match"}, 64'(match), 64'(em));
    chk({nm, "_multi"}, 64'(match_multi), 64'(emu));
    if (em) chk({nm, "_addr"}, 64'(match_addr), 64'(ea));
    chk({nm, "_vec"}, 64'(match_vec), 64'(ev));
  endtask

  initial begin
    int n;
    tv[0] = '{1'b0, 1'b0, 5'd3, 16'hBEEF, 2, 1'b0, 1'b0, 5'd0, 32'h0000_0000, 1};
    tv[1] = '{1'b1, 1'b0, 5'd0, 16'hBEEF, 0, 1'b1, 1'b0, 5'd3, 32'h0000_0008, 0};
    tv[2] = '{1'b0, 1'b0, 5'd7, 16'hBEEF, 2, 1'b0, 1'b0, 5'd0, 32'h0000_0000, 2};
    tv[3] = '{1'b1, 1'b0, 5'd0, 16'hBEEF, 0, 1'b1, 1'b1, 5'd3, 32'h0000_0088, 0};
    tv[4] = '{1'b0, 1'b0, 5'd3, 16'h1234, 4, 1'b0, 1'b0, 5'd0, 32'h0000_0000, 2};
    tv[5] = '{1'b1, 1'b0, 5'd0, 16'hBEEF, 0, 1'b1, 1'b0, 5'd7, 32'h0000_0080, 0};
    tv[6] = '{1'b1, 1'b0, 5'd0, 16'h1234, 0, 1'b1, 1'b0, 5'd3, 32'h0000_0008, 0};
    tv[7] = '{1'b1, 1'b0, 5'd0, 16'h1235, 0, 1'b0, 1'b0, 5'd0, 32'h0000_0000, 0};
    tv[8] = '{1'b1, 1'b0, 5'd0, 16'h0000, 0, 1'b0, 1'b0, 5'd0, 32'h0000_0000, 0};

    rst = 1'b1; clear = 1'b0; wr_valid = 1'b0; wr_op = 1'b0;
    wr_addr = 5'd0; wr_data = 16'h0000; cmp_valid = 1'b0; cmp_data = 16'h0000;
    step(); step(); step();
    chk("rst_wr_ready", 64'(wr_ready), 64'd0);
    chk("rst_match_valid", 64'(match_valid), 64'd0);
    chk("rst_match", 64'(match), 64'd0);
    chk("rst_multi", 64'(match_multi), 64'd0);
    chk("rst_addr", 64'(match_addr), 64'd0);
    chk("rst_vec", 64'(match_vec), 64'd0);
    chk("rst_entry_valid", 64'(entry_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    rst = 1'b0;

    n = 0;
    while (!wr_ready && n < 40) begin
      step();
      n++;
    end
    chk("init_len_reset", 64'(n), 64'd16);
    do_cmp(16'h0000, 1'b0, 1'b0, 5'd0, 32'h0, "cmp_after_init");

    for (int i = 0; i < 9; i++) begin
      if (tv[i].is_cmp) begin
        do_cmp(tv[i].data, tv[i].em, tv[i].emu, tv[i].ea, tv[i].ev, $sformatf("v%0d", i));
      end else begin
        do_wr(tv[i].op, tv[i].addr, tv[i].data, tv[i].busy, $sformatf("v%0d", i));
        chk($sformatf("v%0d_count", i), 64'(count), 64'(tv[i].cnt));
      end
    end
    chk("table_entry_valid", 64'(entry_valid), 64'h88);

    // Delete addr 7 with a compare of its data in the acceptance cycle.
    wr_valid = 1'b1; wr_op = 1'b1; wr_addr = 5'd7;
    cmp_valid = 1'b1; cmp_data = 16'hBEEF;
    chk("del7_ready", 64'(wr_ready), 64'd1);
    step();
    wr_valid = 1'b0; cmp_valid = 1'b0;
    chk("del7_busy1", 64'(wr_ready), 64'd0);
    step();
    chk("del7_cmp_mvalid", 64'(match_valid), 64'd1);
    chk("del7_cmp_match", 64'(match), 64'd0);
    chk("del7_cmp_vec", 64'(match_vec), 64'd0);
    chk("del7_busy2", 64'(wr_ready), 64'd0);
    step();
    chk("del7_done", 64'(wr_ready), 64'd1);
    do_wr(1'b1, 5'd9, 16'h0000, 0, "del9");
    step();
    chk("del9_ready_held", 64'(wr_ready), 64'd1);
    chk("del_count", 64'(count), 64'd1);
    chk("del_entry_valid", 64'(entry_valid), 64'h08);
    do_cmp(16'hBEEF, 1'b0, 1'b0, 5'd0, 32'h0, "after_del_beef");
    do_cmp(16'h1234, 1'b1, 1'b0, 5'd3, 32'h08, "after_del_1234");

    // Fill the table, then abort an overwrite with clear.
    for (int i = 0; i < 32; i++) begin
      do_wr(1'b0, 5'(i), 16'(16'h0100 + i), (i == 3) ? 4 : 2, $sformatf("fill%0d", i));
    end
    chk("fill_count", 64'(count), 64'd32);
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_entry_valid", 64'(entry_valid), 64'hFFFF_FFFF);
    do_cmp(16'h0105, 1'b1, 1'b0, 5'd5, 32'h20, "fill_cmp5");
    do_wr(1'b0, 5'd5, 16'h0105, 4, "full_overwrite5");
    chk("full_overwrite_count", 64'(count), 64'd32);

    wr_valid = 1'b1; wr_op = 1'b0; wr_addr = 5'd10; wr_data = 16'hAAAA;
    step();
    wr_valid = 1'b0;
    chk("abort_busy", 64'(wr_ready), 64'd0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clear_count", 64'(count), 64'd0);
    chk("clear_full", 64'(full), 64'd0);
    chk("clear_entry_valid", 64'(entry_valid), 64'd0);
    chk("clear_wr_ready", 64'(wr_ready), 64'd0);
    do_cmp(16'h010A, 1'b0, 1'b0, 5'd0, 32'h0, "init_cmp");
    n = 2;
    while (!wr_ready && n < 40) begin
      step();
      n++;
    end
    chk("init_len_clear", 64'(n), 64'd16);
    do_cmp(16'h0105, 1'b0, 1'b0, 5'd0, 32'h0, "post_clear_0105");
    do_wr(1'b0, 5'd5, 16'h2222, 2, "post_clear_w5");
    do_cmp(16'h0105, 1'b0, 1'b0, 5'd0, 32'h0, "wiped_0105");
    do_cmp(16'h2222, 1'b1, 1'b0, 5'd5, 32'h20, "new_2222");
    do_cmp(16'hAAAA, 1'b0, 1'b0, 5'd0, 32'h0, "aborted_aaaa");
    chk("final_count", 64'(count), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
